// File: rtl/step_sequencer.sv
// Microcode step sequencer: step counter and datapath clock enable for SAP1.
// Define STEP_SEQUENCER_INSTR_COUNT_EN to build the retired-instruction counter.
module step_sequencer #(
  parameter int INSTRUCTION_STEPS = 8,
  parameter int STEP_WIDTH = $clog2(INSTRUCTION_STEPS),
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_run,
  input  logic                   i_step_req,
  input  logic                   i_resume,
  input  logic                   i_adv,
  input  logic                   i_hlt,
  output logic [STEP_WIDTH-1:0]  o_step,
  output logic                   o_clk_en,
  output logic                   o_halted,
  output logic                   o_overrun,
  output logic [COUNT_WIDTH-1:0] o_instr_count
);

  typedef enum logic [1:0] {
    PAUSE,
    RUN,
    HALTED
  } state_e;

  localparam logic [STEP_WIDTH-1:0] LAST =
    STEP_WIDTH'(INSTRUCTION_STEPS - 1);

  state_e                state_q, state_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  halted_q, halted_d;
  logic                  overrun_q, overrun_d;
  logic                  req_q;
  logic                  step_pulse;
  logic                  clk_en;

  assign step_pulse = i_step_req & ~req_q;
  assign clk_en = (state_q == RUN) |
                  ((state_q == PAUSE) & step_pulse);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    halted_d  = halted_q;
    overrun_d = overrun_q;
    unique case (state_q)
      HALTED: begin
        if (i_resume) begin
          step_d   = '0;
          halted_d = 1'b0;
          state_d  = i_run ? RUN : PAUSE;
        end
      end
      default: begin
        state_d = i_run ? RUN : PAUSE;
        // Halt beats both a mode change and c_ADV; step holds on c_HLT.
        if (clk_en) begin
          if (i_hlt) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else if (i_adv) begin
            step_d = '0;
          end else if (step_q == LAST) begin
            step_d    = '0;
            overrun_d = 1'b1;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= PAUSE;
      step_q    <= '0;
      halted_q  <= 1'b0;
      overrun_q <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      halted_q  <= halted_d;
      overrun_q <= overrun_d;
      req_q     <= i_step_req;
    end
  end

`ifdef STEP_SEQUENCER_INSTR_COUNT_EN
  logic [COUNT_WIDTH-1:0] count_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else if (clk_en & i_adv & ~i_hlt) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign o_instr_count = count_q;
`else
  assign o_instr_count = '0;
`endif

  assign o_step    = step_q;
  assign o_clk_en  = clk_en;
  assign o_halted  = halted_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed self-checking bench for step_sequencer (INSTRUCTION_STEPS=8).
module tb_step_sequencer;

`ifdef STEP_SEQUENCER_INSTR_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, run, step_req, resume, adv, hlt;
  logic [2:0]  step;
  logic        clk_en, halted, overrun;
  logic [15:0] cnt;
  int          checks = 0;
  int          errors = 0;

  step_sequencer #(
    .INSTRUCTION_STEPS(8),
    .COUNT_WIDTH(16)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_run(run),
    .i_step_req(step_req),
    .i_resume(resume),
    .i_adv(adv),
    .i_hlt(hlt),
    .o_step(step),
    .o_clk_en(clk_en),
    .o_halted(halted),
    .o_overrun(overrun),
    .o_instr_count(cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    step_req = 1'b0;
    resume = 1'b0;
    adv = 1'b0;
    hlt = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (step !== 3'd0) begin
      errors++;
      $display("FAIL reset_step: got %0d want 0", step);
    end
    checks++;
    if (clk_en !== 1'b0 || halted !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: en=%b hlt=%b ovr=%b want 000",
               clk_en, halted, overrun);
    end
    checks++;
    if (cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", cnt);
    end
  endtask

  task automatic test_free_run();
    int e;
    do_reset();
    run = 1'b1;
    #1;
    checks++;
    if (clk_en !== 1'b0) begin
      errors++;
      $display("FAIL run_first_en: got %b want 0", clk_en);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      e = i % 4;
      adv = (e == 3);
      #1;
      checks++;
      if (clk_en !== 1'b1 || step !== 3'(e)) begin
        errors++;
        $display("FAIL run_cycle%0d: en=%b step=%0d want en=1 step=%0d",
                 i, clk_en, step, e);
      end
      tick();
    end
    adv = 1'b0;
    #1;
    checks++;
    if (step !== 3'd2) begin
      errors++;
      $display("FAIL run_end_step: got %0d want 2", step);
    end
    checks++;
    if (cnt !== (CntEn ? 16'd2 : 16'd0)) begin
      errors++;
      $display("FAIL run_count: got %0d want %0d", cnt, CntEn ? 2 : 0);
    end
  endtask

  task automatic test_single_step();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step_req = 1'b1;
      #1;
      checks++;
      if (clk_en !== (i == 0) || step !== ((i == 0) ? 3'd0 : 3'd1)) begin
        errors++;
        $display("FAIL sstep_hold%0d: en=%b step=%0d want en=%b step=%0d",
                 i, clk_en, step, i == 0, (i == 0) ? 0 : 1);
      end
      tick();
    end
    step_req = 1'b0;
    tick();
    step_req = 1'b1;
    #1;
    checks++;
    if (clk_en !== 1'b1) begin
      errors++;
      $display("FAIL sstep_second_en: got %b want 1", clk_en);
    end
    tick();
    step_req = 1'b0;
    #1;
    checks++;
    if (step !== 3'd2 || clk_en !== 1'b0) begin
      errors++;
      $display("FAIL sstep_second: step=%0d en=%b want step=2 en=0",
               step, clk_en);
    end
  endtask

  task automatic test_halt();
    do_reset();
    run = 1'b1;
    tick();
    tick();
    tick();
    hlt = 1'b1;
    #1;
    checks++;
    if (clk_en !== 1'b1 || step !== 3'd2 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_take: en=%b step=%0d hlt=%b want 1 2 0",
               clk_en, step, halted);
    end
    tick();
    for (int j = 0; j < 4; j++) begin
      step_req = j[0];
      run = j[1];
      #1;
      checks++;
      if (clk_en !== 1'b0 || step !== 3'd2 || halted !== 1'b1) begin
        errors++;
        $display("FAIL halt_hold%0d: en=%b step=%0d hlt=%b want 0 2 1",
                 j, clk_en, step, halted);
      end
      tick();
    end
    step_req = 1'b0;
    run = 1'b1;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    hlt = 1'b0;
    #1;
    checks++;
    if (step !== 3'd0 || halted !== 1'b0 || clk_en !== 1'b1) begin
      errors++;
      $display("FAIL halt_resume: step=%0d hlt=%b en=%b want 0 0 1",
               step, halted, clk_en);
    end
    tick();
    checks++;
    if (step !== 3'd1) begin
      errors++;
      $display("FAIL halt_after_resume: step=%0d want 1", step);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (step !== 3'(i) || overrun !== 1'b0) begin
        errors++;
        $display("FAIL ovr_walk%0d: step=%0d ovr=%b want %0d 0",
                 i, step, overrun, i);
      end
      tick();
    end
    checks++;
    if (step !== 3'd0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_wrap: step=%0d ovr=%b want 0 1", step, overrun);
    end
    for (int i = 0; i < 4; i++) begin
      adv = (i == 3);
      tick();
    end
    adv = 1'b0;
    #1;
    checks++;
    if (step !== 3'd0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: step=%0d ovr=%b want 0 1", step, overrun);
    end
    checks++;
    if (cnt !== (CntEn ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL ovr_count: got %0d want %0d", cnt, CntEn ? 1 : 0);
    end
  endtask

  task automatic test_hlt_adv();
    do_reset();
    run = 1'b1;
    tick();
    tick();
    tick();
    hlt = 1'b1;
    adv = 1'b1;
    tick();
    #1;
    checks++;
    if (halted !== 1'b1 || step !== 3'd2 || clk_en !== 1'b0) begin
      errors++;
      $display("FAIL hltadv_state: hlt=%b step=%0d en=%b want 1 2 0",
               halted, step, clk_en);
    end
    checks++;
    if (cnt !== 16'd0) begin
      errors++;
      $display("FAIL hltadv_count: got %0d want 0", cnt);
    end
    hlt = 1'b0;
    adv = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) begin
      adv = (i == 11);
      tick();
    end
    checks++;
    if (step !== 3'd3 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre: step=%0d ovr=%b want 3 1", step, overrun);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (step !== 3'd0 || overrun !== 1'b0 || halted !== 1'b0 ||
        clk_en !== 1'b0 || cnt !== 16'd0) begin
      errors++;
      $display("FAIL rmid_async: step=%0d ovr=%b hlt=%b en=%b cnt=%0d want 0",
               step, overrun, halted, clk_en, cnt);
    end
    run = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (clk_en !== 1'b0 || step !== 3'd0) begin
        errors++;
        $display("FAIL rmid_idle%0d: en=%b step=%0d want 0 0",
                 i, clk_en, step);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_single_step();
    test_halt();
    test_overrun();
    test_hlt_adv();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Microcode step sequencer for the SAP1 control path. It owns the registered step counter that drives the instruction decoder's step input. It consumes the decoder's advance (c_ADV) and halt (c_HLT) control bits and produces the datapath clock enable for free-run, single-step and halted operation. It sits between the front-panel run/step inputs and every datapath register, so each datapath register loads only on cycles this block enables.

## Interface
Parameters:
- INSTRUCTION_STEPS, 8: microcode steps per instruction. Must be a power of two, ≥ 4.
- STEP_WIDTH, $clog2(INSTRUCTION_STEPS): width of the step output.
- COUNT_WIDTH, 16: width of the retired-instruction counter (only with the macro below).

Ports:
- i_clk, input, 1: system clock, rising edge.
- i_reset, input, 1: reset; asynchronous and active-high.
- i_run, input, 1: level; 1 = free-run, 0 = pause/single-step.
- i_step_req, input, 1: synchronous single-step request; the rising edge counts.
- i_resume, input, 1: synchronous pulse; leaves HALTED.
- i_adv, input, 1: c_ADV bit of the current control word.
- i_hlt, input, 1: c_HLT bit of the current control word.
- o_step, output, STEP_WIDTH: current microcode step, fed to the decoder.
- o_clk_en, output, 1: datapath register enable for this cycle.
- o_halted, output, 1: 1 while in HALTED.
- o_overrun, output, 1: sticky; set when a step sequence ran off the end without c_ADV.
- o_instr_count, output, COUNT_WIDTH: retired instructions (macro-gated).

## Operation
- States: PAUSE (reset state), RUN, HALTED. State is registered.
- Edge detect:
  - req_q is i_step_req registered, reset to 0.
  - step_pulse = i_step_req & ~req_q.
- Enable: o_clk_en = (state==RUN) | (state==PAUSE & step_pulse). It is combinational from registered state, req_q and i_step_req. It is always 0 in HALTED.
- Step update occurs only when o_clk_en=1, in priority order:
  - i_hlt: state ← HALTED; o_step holds its value.
  - i_adv: o_step ← 0.
  - o_step == INSTRUCTION_STEPS-1: o_step ← 0 and o_overrun ← 1.
  - otherwise: o_step ← o_step+1.
- The step counter wraps only through the i_adv path or the overrun path. It never uses natural overflow.
- Mode transitions, evaluated every cycle outside HALTED:
  - PAUSE → RUN when i_run=1.
  - RUN → PAUSE when i_run=0.
  - A mode change takes effect on the next cycle's o_clk_en.
- Halt precedence: if i_hlt is taken in the same cycle i_run changes, the next state is HALTED.
- HALTED:
  - o_clk_en=0.
  - o_step stays at the halting step, so the decoder keeps presenting c_HLT.
  - i_step_req and i_run are ignored.
  - i_resume=1 → o_step ← 0, o_halted ← 0, state ← (i_run ? RUN : PAUSE).
- i_resume outside HALTED has no effect.
- Simultaneous i_hlt and i_adv: halt wins and the step holds.
- o_overrun is cleared only by reset.

## Timing
- All outputs are registered except o_clk_en.
- Reset values: o_step=0, state=PAUSE, o_halted=0, o_overrun=0, o_instr_count=0, req_q=0. Consequently o_clk_en=0 unless a step edge is present.
- Asynchronous reset mid-instruction returns the counter to step 0 immediately, with no completion of the current step.
- Latency: a control word enabled on edge N updates o_step at edge N. The decoder sees the new step in cycle N+1.
- Free-run throughput: one microstep per clock. A 4-step instruction (fetch 0, fetch 1, then steps 2 and 3) retires in 4 cycles.
- Single-step: exactly one enabled cycle per i_step_req rising edge. Holding i_step_req high yields one step only.
- o_halted rises one clock after the enabled cycle that carried i_hlt.

## Configuration
- STEP_SEQUENCER_INSTR_COUNT_EN defined:
  - o_instr_count increments by 1 on each enabled cycle with i_adv=1 and i_hlt=0.
  - The counter wraps modulo 2^COUNT_WIDTH.
- Undefined: o_instr_count is tied to 0 and no counter flops are built.

## Test plan
- Reset then i_run=1, with i_adv asserted whenever o_step=3 → o_step cycles 0,1,2,3,0; o_clk_en=1 every cycle; count increments every 4 clocks.
- i_run=0, hold i_step_req high for 5 cycles → exactly one o_clk_en pulse; o_step 0→1 and holds.
- Free-run with i_hlt at step 2 → o_halted=1 next cycle, o_step stays 2, o_clk_en=0; i_step_req toggling has no effect. Then i_resume with i_run=1 → o_step=0 and o_clk_en=1 next cycle.
- i_adv never asserted (INSTRUCTION_STEPS=8) → after step 7, o_step=0 and o_overrun=1, staying set through later normal instructions.
- i_hlt and i_adv together at step 2 → HALTED, o_step=2, count unchanged.
- Assert i_reset at step 3 while RUN → o_step=0, state PAUSE, o_overrun=0, o_instr_count=0 asynchronously; no o_clk_en after release until i_run or a step edge.
